// File: rtl/mac_ctrl.sv
`timescale 1ns/1ps
// Purpose: Moore sequencer driving one MAC datapath through an N_TERMS-term dot product.
// Latency: result valid after edge 3*N_TERMS+2 from the start edge, plus one cycle per LOAD stall.
// Backpressure: in_valid/in_ready for operands; out_valid is held until out_ack; abort cancels at once.
module mac_ctrl #(
   parameter int N_TERMS = 50,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic abort,
   input  logic in_valid,
   output logic in_ready,
   input  logic tc,
   input  logic out_ack,
   output logic ld_a,
   output logic ld_b,
   output logic ld_acc,
   output logic ld_out,
   output logic count_en,
   output logic ld_count,
   output logic dp_clr,
   output logic busy,
   output logic out_valid,
   output logic cnt_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_LOAD  = 3'd2,
      S_MAC   = 3'd3,
      S_CHECK = 3'd4,
      S_STORE = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] term_cnt;
   logic             last_term;

   // The internal count alone decides when the run ends; tc is only cross-checked.
   assign last_term = (term_cnt == LAST_TERM);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides every other transition out of a busy state.
   always_comb begin
      state_nxt = state;
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start && !abort) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_LOAD;
            S_LOAD:  if (in_valid) state_nxt = S_MAC;
            S_MAC:   state_nxt = S_CHECK;
            S_CHECK: state_nxt = last_term ? S_STORE : S_LOAD;
            S_STORE: state_nxt = S_DONE;
            S_DONE:  if (out_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Term counter: cleared alongside the datapath, advanced with each MAC unless aborted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         term_cnt <= '0;
      end else if (!abort) begin
         if (state == S_CLR) begin
            term_cnt <= '0;
         end else if (state == S_MAC) begin
            term_cnt <= term_cnt + 1'b1;
         end
      end
   end

   // Sticky mismatch flag: cleared only when a new run is accepted, set on any tc disagreement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_err <= 1'b0;
      end else if ((state == S_IDLE) && start && !abort) begin
         cnt_err <= 1'b0;
      end else if ((state == S_CHECK) && !abort && (tc != last_term)) begin
         cnt_err <= 1'b1;
      end
   end

   // Output decode from state; datapath strobes are suppressed in an abort cycle so nothing
   // in the datapath moves while the run is being cancelled.
   always_comb begin
      in_ready  = (state == S_LOAD);
      busy      = (state != S_IDLE);
      out_valid = (state == S_DONE);
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      ld_acc    = 1'b0;
      count_en  = 1'b0;
      ld_out    = 1'b0;
      ld_count  = 1'b0;
      dp_clr    = 1'b0;
      if (!abort) begin
         case (state)
            S_CLR: dp_clr = 1'b1;
            S_LOAD: begin
               ld_a = in_valid;
               ld_b = in_valid;
            end
            S_MAC: begin
               ld_acc   = 1'b1;
               count_en = 1'b1;
            end
            S_STORE: begin
               ld_out   = 1'b1;
               ld_count = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_ctrl.sv
`timescale 1ns/1ps
// Purpose: randomized bench for mac_ctrl with a behavioural MAC datapath around it.
// Latency: expected result timing and sums are derived from operand/stall lists per run.
// Backpressure: exercises in_valid stalls, held out_ack, abort and mid-run reset.
module tb_mac_ctrl;

   localparam int N = 50;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic in_valid = 1'b0;
   logic out_ack = 1'b0;
   logic tc;
   logic in_ready, ld_a, ld_b, ld_acc, ld_out, count_en, ld_count, dp_clr, busy, out_valid, cnt_err;

   // datapath environment
   logic [7:0]  a_in = '0;
   logic [7:0]  b_in = '0;
   logic [7:0]  a_q = '0;
   logic [7:0]  b_q = '0;
   logic [31:0] acc = '0;
   logic [31:0] out_q = '0;
   logic [7:0]  count_q = '0;
   logic [7:0]  cnt_snap = '0;
   logic        force_tc0 = 1'b0;
   int          n_acc = 0;
   int          n_out = 0;
   int          n_clr = 0;

   // per-run stimulus
   logic [7:0]  op_a [N];
   logic [7:0]  op_b [N];
   int          stall_n [N];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign tc = force_tc0 ? 1'b0 : (count_q == 8'(N));

   mac_ctrl #(.N_TERMS(N), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .tc(tc), .out_ack(out_ack),
      .ld_a(ld_a), .ld_b(ld_b), .ld_acc(ld_acc), .ld_out(ld_out),
      .count_en(count_en), .ld_count(ld_count), .dp_clr(dp_clr),
      .busy(busy), .out_valid(out_valid), .cnt_err(cnt_err)
   );

   // Behavioural datapath responding to the controller strobes, plus pulse counters.
   always @(posedge clk) begin
      if (dp_clr) begin
         acc     <= '0;
         count_q <= '0;
      end else begin
         if (ld_acc)   acc     <= acc + 32'(a_q) * 32'(b_q);
         if (count_en) count_q <= count_q + 8'd1;
      end
      if (ld_a)     a_q      <= a_in;
      if (ld_b)     b_q      <= b_in;
      if (ld_out)   out_q    <= acc;
      if (ld_count) cnt_snap <= count_q;
      n_acc <= n_acc + int'(ld_acc);
      n_out <= n_out + int'(ld_out);
      n_clr <= n_clr + int'(dp_clr);
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: all ones, 1: all 255, 2: random; stalls cleared
   task automatic fill_ops(input int mode);
      for (int i = 0; i < N; i++) begin
         op_a[i]    = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
         op_b[i]    = (mode == 0) ? 8'd1 : (mode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
         stall_n[i] = 0;
      end
   endtask

   task automatic run_one(input string tag, input int abort_term, input int reset_term,
                          input bit exp_err, input int hold);
      int exp_sum;
      int exp_lat;
      int idx;
      int e;
      int left;
      int acc0;
      int out0;
      int clr0;
      logic [31:0] out_before;
      exp_sum    = 0;
      exp_lat    = 3 * N + 2;
      idx        = 0;
      e          = 0;
      acc0       = n_acc;
      out0       = n_out;
      clr0       = n_clr;
      out_before = out_q;
      for (int i = 0; i < N; i++) begin
         exp_sum += int'(op_a[i]) * int'(op_b[i]);
         exp_lat += stall_n[i];
      end
      left = stall_n[0];

      @(negedge clk);
      start    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, " err_clr_on_start"}, cnt_err, 0);
      check({tag, " dp_clr"}, dp_clr, 1);

      while (e < 2000) begin
         if (out_valid) break;
         in_valid = 1'($urandom_range(0, 1));
         a_in     = 8'($urandom_range(0, 255));
         b_in     = 8'($urandom_range(0, 255));
         if (in_ready) begin
            if ((reset_term != 0) && (idx == reset_term - 1)) begin
               in_valid = 1'b1;
               reset    = 1'b0;
               #1;
               check({tag, " reset_outs"},
                     {in_ready, ld_a, ld_b, ld_acc, ld_out, count_en, ld_count,
                      dp_clr, busy, out_valid, cnt_err}, 0);
               @(negedge clk);
               reset    = 1'b1;
               in_valid = 1'b0;
               @(negedge clk);
               check({tag, " idle_after_reset"}, {busy, in_ready, out_valid}, 0);
               return;
            end
            if (left > 0) begin
               left--;
               in_valid = 1'b0;
               #1;
               check({tag, " stall_quiet"}, {ld_a, ld_b, ld_acc, count_en}, 0);
            end else begin
               in_valid = 1'b1;
               a_in     = op_a[idx];
               b_in     = op_b[idx];
               idx++;
               if (idx < N) left = stall_n[idx];
            end
         end
         if (ld_acc && (abort_term != 0) && (idx == abort_term)) begin
            abort = 1'b1;
            #1;
            check({tag, " abort_no_strobe"}, {ld_acc, count_en}, 0);
            @(negedge clk);
            abort = 1'b0;
            check({tag, " abort_idle"}, {busy, out_valid}, 0);
            @(negedge clk);
            check({tag, " abort_no_ld_out"}, n_out - out0, 0);
            check({tag, " abort_out_kept"}, out_q, out_before);
            check({tag, " abort_acc_pulses"}, n_acc - acc0, abort_term - 1);
            return;
         end
         @(posedge clk);
         e++;
         @(negedge clk);
      end

      in_valid = 1'b0;
      check({tag, " latency"}, e, exp_lat);
      check({tag, " ld_acc_pulses"}, n_acc - acc0, N);
      check({tag, " ld_out_pulses"}, n_out - out0, 1);
      check({tag, " clr_pulses"}, n_clr - clr0, 1);
      check({tag, " out_sum"}, out_q, exp_sum);
      check({tag, " count_snap"}, cnt_snap, N);
      check({tag, " cnt_err"}, cnt_err, exp_err);

      for (int i = 0; i < hold; i++) begin
         start = (i == hold / 2);
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, " out_valid_held"}, {out_valid, busy}, 2'b11);
      out_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ack = 1'b0;
      check({tag, " ack_to_idle"}, {out_valid, busy}, 0);
      @(negedge clk);
      @(negedge clk);
      check({tag, " start_not_queued"}, n_clr - clr0, 1);
      check({tag, " stays_idle"}, busy, 0);
   endtask

   initial begin
      fill_ops(0);
      repeat (3) @(negedge clk);
      check("reset_state",
            {in_ready, ld_a, ld_b, ld_acc, ld_out, count_en, ld_count,
             dp_clr, busy, out_valid, cnt_err}, 0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_release", {busy, dp_clr, out_valid}, 0);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("start_abort_idle", {busy, dp_clr}, 0);

      fill_ops(0);
      run_one("ones", 0, 0, 1'b0, 2);

      fill_ops(1);
      stall_n[9]  = 3;
      stall_n[39] = 3;
      run_one("max_stall", 0, 0, 1'b0, 20);

      fill_ops(2);
      force_tc0 = 1'b1;
      run_one("tc_forced", 0, 0, 1'b1, 3);
      force_tc0 = 1'b0;

      fill_ops(2);
      run_one("abort25", 25, 0, 1'b0, 0);
      fill_ops(2);
      run_one("after_abort", 0, 0, 1'b0, 1);

      fill_ops(2);
      run_one("reset7", 0, 7, 1'b0, 0);
      fill_ops(2);
      run_one("after_reset", 0, 0, 1'b0, 1);

      for (int r = 0; r < 4; r++) begin
         fill_ops(2);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) stall_n[i] = $urandom_range(1, 4);
         end
         run_one($sformatf("rand%0d", r), 0, 0, 1'b0, $urandom_range(0, 6));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
